// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int                   DIV_CNT_W = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_ITER  = 6'd32;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division iteration (combinational)
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0]   rem_sh;
    logic [W+1:0] diff;

    // One extra bit on the trial difference so its MSB is a clean borrow flag
    assign rem_sh = {rem_i[W-1:0], quo_i[W-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dvs_i};

    always_comb begin
        if (diff[W+1]) begin
            rem_o = rem_sh;
            quo_o = {quo_i[W-2:0], 1'b0};
        end else begin
            rem_o = diff[W:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned restoring divider
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Dividendo,
    input  logic [WIDTH-1:0]     Divisor,
    output logic                 Busy,
    output logic                 Done,
    output logic                 DivZero,
    output logic [WIDTH-1:0]     Lo,
    output logic [WIDTH-1:0]     Hi,
    output logic [DIV_CNT_W-1:0] Contador
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d, step_rem;
    logic [WIDTH-1:0]     quo_q, quo_d, step_quo;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     lo_q, lo_d, hi_q, hi_d;
    logic                 qneg_q, qneg_d, rneg_q, rneg_d;
    logic                 divzero_q, divzero_d;
    logic                 dvd_neg, dvs_neg;

    div_step #(.W(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign dvd_neg = Signed & Dividendo[WIDTH-1];
    assign dvs_neg = Signed & Divisor[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        divzero_d = divzero_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Divisor == '0) begin
                        divzero_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        // The quotient register starts out holding |dividend|; it shifts into rem
                        quo_d     = dvd_neg ? (~Dividendo + 1'b1) : Dividendo;
                        dvs_d     = dvs_neg ? (~Divisor + 1'b1) : Divisor;
                        qneg_d    = dvd_neg ^ dvs_neg;
                        rneg_d    = dvd_neg;
                        rem_d     = '0;
                        cnt_d     = DIV_ITER;
                        divzero_d = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 6'd1) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                lo_d    = qneg_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            divzero_q <= divzero_d;
        end
    end

    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign DivZero  = divzero_q;
    assign Lo       = lo_q;
    assign Hi       = hi_q;
    assign Contador = cnt_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] Dividendo;
    logic [31:0] Divisor;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] Lo;
    logic [31:0] Hi;
    logic [5:0]  Contador;

    int vectors;
    int miscompares;
    int ncyc;

    div_unit #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Lo        (Lo),
        .Hi        (Hi),
        .Contador  (Contador)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Leaves the bench at the falling edge just after the sampling edge t
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start     = 1'b1;
        Signed    = s;
        Dividendo = a;
        Divisor   = b;
        @(negedge Clk);
        Start     = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b0;
        Start       = 1'b0;
        Signed      = 1'b0;
        Dividendo   = '0;
        Divisor     = '0;
        repeat (2) @(negedge Clk);

        chk("rst_busy",    {31'd0, Busy},    32'd0);
        chk("rst_done",    {31'd0, Done},    32'd0);
        chk("rst_divzero", {31'd0, DivZero}, 32'd0);
        chk("rst_lo",      Lo,               32'd0);
        chk("rst_hi",      Hi,               32'd0);
        chk("rst_cnt",     {26'd0, Contador}, 32'd0);
        Reset = 1'b1;

        launch(1'b0, 32'd100, 32'd7);
        chk("u100_busy_t", {31'd0, Busy}, 32'd1);
        chk("u100_cnt_t",  {26'd0, Contador}, 32'd32);
        wait_done(ncyc);
        chk("u100_lat",    ncyc, 32'd33);
        chk("u100_lo",     Lo, 32'd14);
        chk("u100_hi",     Hi, 32'd2);
        chk("u100_dz",     {31'd0, DivZero}, 32'd0);
        @(negedge Clk);
        chk("u100_done_1", {31'd0, Done}, 32'd0);
        chk("u100_busy_1", {31'd0, Busy}, 32'd0);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(ncyc);
        chk("sm7_lat", ncyc, 32'd33);
        chk("sm7_lo",  Lo, 32'hFFFF_FFFD);
        chk("sm7_hi",  Hi, 32'hFFFF_FFFF);

        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(ncyc);
        chk("s7m2_lo", Lo, 32'hFFFF_FFFD);
        chk("s7m2_hi", Hi, 32'd1);

        launch(1'b1, 32'd5, 32'd0);
        chk("dz_lat",   ncyc * 0 + {31'd0, Done}, 32'd1);
        chk("dz_flag",  {31'd0, DivZero}, 32'd1);
        chk("dz_busy",  {31'd0, Busy}, 32'd1);
        chk("dz_lo",    Lo, 32'hFFFF_FFFD);
        chk("dz_hi",    Hi, 32'd1);
        @(negedge Clk);
        chk("dz_done_1", {31'd0, Done}, 32'd0);
        chk("dz_busy_1", {31'd0, Busy}, 32'd0);
        chk("dz_hold",   {31'd0, DivZero}, 32'd1);

        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("dz_clear", {31'd0, DivZero}, 32'd0);
        wait_done(ncyc);
        chk("sext_lat", ncyc, 32'd33);
        chk("sext_lo",  Lo, 32'h8000_0000);
        chk("sext_hi",  Hi, 32'd0);
        chk("sext_dz",  {31'd0, DivZero}, 32'd0);

        launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(ncyc);
        chk("umax1_lo", Lo, 32'hFFFF_FFFF);
        chk("umax1_hi", Hi, 32'd0);

        launch(1'b0, 32'd3, 32'hFFFF_FFFF);
        wait_done(ncyc);
        chk("u3max_lo", Lo, 32'd0);
        chk("u3max_hi", Hi, 32'd3);

        launch(1'b0, 32'd1000, 32'd10);
        repeat (5) @(negedge Clk);
        chk("ign_cnt", {26'd0, Contador}, 32'd27);
        Start     = 1'b1;
        Signed    = 1'b1;
        Dividendo = 32'd9;
        Divisor   = 32'd0;
        @(negedge Clk);
        Start     = 1'b0;
        wait_done(ncyc);
        chk("ign_lat", ncyc, 32'd27);
        chk("ign_lo",  Lo, 32'd100);
        chk("ign_hi",  Hi, 32'd0);
        chk("ign_dz",  {31'd0, DivZero}, 32'd0);

        launch(1'b0, 32'd50, 32'd3);
        repeat (10) @(negedge Clk);
        chk("rr_cnt", {26'd0, Contador}, 32'd22);
        Reset = 1'b0;
        #1;
        chk("rr_busy", {31'd0, Busy}, 32'd0);
        chk("rr_done", {31'd0, Done}, 32'd0);
        chk("rr_lo",   Lo, 32'd0);
        chk("rr_hi",   Hi, 32'd0);
        chk("rr_cnt0", {26'd0, Contador}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        ncyc  = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done === 1'b1) ncyc++;
        end
        chk("rr_no_done", ncyc, 32'd0);
        chk("rr_idle",    {31'd0, Busy}, 32'd0);
        chk("rr_lo_hold", Lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the multicycle MIPS datapath, the divide-side sibling of the multiplier. It serves `div` and `divu`. It takes the dividend from register A and the divisor from register B. It produces quotient and remainder for the LO/HI write-back path. The controller launches it with a one-cycle start pulse and waits on `Done`. It also receives a divide-by-zero flag and routes it to the exception logic.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `Clk`  input  1  single system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset.
- `Start`  input  1  one-cycle launch pulse from the controller; sampled only in IDLE.
- `Signed`  input  1  1 = `div` (two's complement), 0 = `divu`; sampled with `Start`.
- `Dividendo`  input  32  dividend (register A output); sampled with `Start`.
- `Divisor`  input  32  divisor (register B output); sampled with `Start`.
- `Busy`  output  1  high from the edge after `Start` until `Done` deasserts.
- `Done`  output  1  one-cycle completion pulse.
- `DivZero`  output  1  divide-by-zero flag; valid with `Done`, held until the next accepted `Start`.
- `Lo`  output  32  quotient.
- `Hi`  output  32  remainder.
- `Contador`  output  6  iterations remaining (debug visibility, like the multiplier counter).

## Operation

States are IDLE, RUN, SIGN and DONE.

- **IDLE**
  - `Start`=1 with `Divisor`=0: go to DONE, set `DivZero`=1, leave `Hi`/`Lo` unchanged.
  - `Start`=1 with `Divisor`≠0: latch |dividend| and |divisor|. Magnitudes apply only when `Signed`=1, otherwise raw values. Also latch the quotient sign (sign XOR) and the remainder sign (dividend sign). Clear the partial remainder, set `Contador`=32, clear `DivZero`, go to RUN.
- **RUN**: perform one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep it and set quotient LSB=1; otherwise restore.
  - Decrement `Contador`; when it reaches 0, go to SIGN.
- **SIGN**: write `Lo` = quotient and `Hi` = remainder, each negated if its latched sign is set. Go to DONE.
- **DONE**: `Done`=1 for exactly one cycle, then IDLE.

Arithmetic rules:
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
- For a signed operation, Dividendo = Lo·Divisor + Hi.
- Signed 0x80000000 / 0xFFFFFFFF gives `Lo`=0x80000000, `Hi`=0. This wraps without error and raises no flag.

`Hi`/`Lo` hold their value between operations. Only SIGN updates them.

`Start` is ignored in RUN, SIGN and DONE. There is no queueing.

## Timing

- Reset (asynchronous, `Reset`=0): state = IDLE; `Busy`, `Done`, `DivZero` = 0; `Hi`, `Lo` = 0; `Contador` = 0; internal registers cleared.
- Reset mid-operation aborts immediately; no partial result reaches `Hi`/`Lo`.
- Let `Start` be sampled at edge t.
- Normal divide:
  - RUN covers edges t+1 … t+32.
  - SIGN writes results at edge t+33.
  - `Done` is high between edges t+33 and t+34.
  - `Hi`/`Lo` are valid from edge t+33 onward.
  - `Busy` is high between edges t and t+34.
- Divide by zero:
  - `Done` and `DivZero` are high between edges t and t+1.
  - `Busy` is high for that single cycle.
- The controller must not change register A/B while `Busy`=1. The operands are latched at t, so the result does not depend on them afterward.
- `Start` and reset deassertion in the same cycle: `Start` is ignored.

## Structure

- Shared package `div_pkg`:
  - typedef `div_state_t` (IDLE, RUN, SIGN, DONE);
  - constant `DIV_ITER` = 32;
  - constant `DIV_CNT_W` = 6.
- One combinational sub-module, `div_step`, implements a single restoring iteration:
  - inputs: 33-bit partial remainder, 32-bit quotient, divisor;
  - outputs: next remainder and next quotient.
- The top level holds the FSM, counter, sign latches and output registers.

## Test plan

- **Unsigned basic**: `divu` 100 / 7 gives `Lo`=14, `Hi`=2. `Done` is high exactly one cycle, between edges t+33 and t+34. `Busy` is low afterward.
- **Signed mixed signs**: `div` -7 / 2 gives `Lo`=0xFFFFFFFD and `Hi`=0xFFFFFFFF. Then 7 / -2 gives `Lo`=0xFFFFFFFD and `Hi`=1.
- **Divide by zero**: `div` 5 / 0 gives `Done`=1 and `DivZero`=1 in the cycle after `Start`. `Hi`/`Lo` keep their previous values. The next `Start` clears `DivZero`.
- **Signed extreme**: 0x80000000 / 0xFFFFFFFF gives `Lo`=0x80000000, `Hi`=0, `DivZero`=0.
- **Unsigned extreme**: `divu` 0xFFFFFFFF / 1 gives `Lo`=0xFFFFFFFF, `Hi`=0. `divu` 3 / 0xFFFFFFFF gives `Lo`=0, `Hi`=3.
- **Protocol and reset**:
  - A second `Start` pulsed 5 cycles into RUN is ignored; the first result is unaffected.
  - `Reset`=0 asserted 10 cycles into RUN forces `Busy`=0, `Hi`=`Lo`=0 and `Contador`=0 immediately, with no `Done`.
